// File: rtl/hash_seq_pkg.sv
// Shared definitions for the BLAKE2 core host sequencer, its requester and bench.
package hash_seq_pkg;

    localparam logic [1:0] CMD_CONF  = 2'd0;
    localparam logic [1:0] CMD_START = 2'd1;
    localparam logic [1:0] CMD_DATA  = 2'd2;
    localparam logic [1:0] CMD_LAST  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        CONF,
        DATA,
        WAIT_HASH,
        HASH_OUT
    } state_e;

    // kk byte, nn byte, then the message length little-endian
    function automatic int cfg_bytes(input int ll_w);
        return 2 + ll_w / 8;
    endfunction

endpackage

// File: rtl/hash_seq_if.sv
// Requester byte stream plus the core's byte-serial data/command/digest bus.
interface hash_seq_if;

    logic       msg_valid_i;
    logic [7:0] msg_data_i;
    logic       msg_ready_o;
    logic [7:0] core_data_o;
    logic [1:0] core_cmd_o;
    logic       core_valid_o;
    logic       core_ready_i;
    logic       core_hash_v_i;
    logic [7:0] core_hash_i;

    modport master (
        input  msg_valid_i, msg_data_i, core_ready_i, core_hash_v_i, core_hash_i,
        output msg_ready_o, core_data_o, core_cmd_o, core_valid_o
    );

    modport slave (
        output msg_valid_i, msg_data_i, core_ready_i, core_hash_v_i, core_hash_i,
        input  msg_ready_o, core_data_o, core_cmd_o, core_valid_o
    );

endinterface

// File: rtl/hash_seq_cfg_ser.sv
// Serializes {ll, nn, kk} into config bytes: kk, nn, then ll little-endian.
module hash_seq_cfg_ser
    import hash_seq_pkg::*;
#(
    parameter int LL_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            adv_i,
    input  logic [6:0]      kk_i,
    input  logic [6:0]      nn_i,
    input  logic [LL_W-1:0] ll_i,
    output logic [7:0]      byte_o,
    output logic            last_o
);

    localparam int NB    = cfg_bytes(LL_W);
    localparam int IDX_W = $clog2(NB);

    logic [IDX_W-1:0] idx_q, idx_d;

    assign last_o = (idx_q == IDX_W'(NB - 1));

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (adv_i && !last_o) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        byte_o = 8'h00;
        if (idx_q == '0) begin
            byte_o = {1'b0, kk_i};
        end else if (idx_q == IDX_W'(1)) begin
            byte_o = {1'b0, nn_i};
        end else begin
            for (int i = 0; i < LL_W / 8; i++) begin
                if (idx_q == IDX_W'(i + 2)) byte_o = ll_i[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) idx_q <= '0;
        else     idx_q <= idx_d;
    end

endmodule

// File: rtl/hash_seq.sv
// Frames one BLAKE2 job onto the core bus: config, key/message bytes, digest readback.
// state     | meaning
// IDLE      | waiting for start_i
// CONF      | sending kk, nn, ll bytes with CMD_CONF
// DATA      | forwarding requester bytes (key block then message)
// WAIT_HASH | waiting for first digest byte, timeout counter running
// HASH_OUT  | forwarding digest bytes until nn have been seen
module hash_seq
    import hash_seq_pkg::*;
#(
    parameter int LL_W    = 64,
    parameter int TIMEOUT = 4096
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [6:0]      cfg_kk_i,
    input  logic [6:0]      cfg_nn_i,
    input  logic [LL_W-1:0] cfg_ll_i,
    hash_seq_if.master      bus,
    output logic            hash_valid_o,
    output logic [7:0]      hash_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            error_o
);

    localparam int CNT_W = LL_W + 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [6:0]        kk_q, kk_d, nn_q, nn_d, hcnt_q, hcnt_d;
    logic [LL_W-1:0]   ll_q, ll_d;
    logic [CNT_W-1:0]  total_q, total_d, sent_q, sent_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              error_q, error_d, done_q, done_d;
    logic              hv_q, hv_d, dv_q, dv_d;
    logic [7:0]        hash_q, hash_d, data_q, data_d;
    logic [1:0]        cmd_q, cmd_d;
    logic              ser_clr, ser_adv, ser_last, msg_ready;
    logic [7:0]        ser_byte;
    logic [6:0]        nn_eff;

    hash_seq_cfg_ser #(.LL_W(LL_W)) u_cfg_ser (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (ser_clr),
        .adv_i  (ser_adv),
        .kk_i   (kk_q),
        .nn_i   (nn_q),
        .ll_i   (ll_q),
        .byte_o (ser_byte),
        .last_o (ser_last)
    );

    assign nn_eff = (nn_q == 7'd0) ? 7'd64 : nn_q;
    assign msg_ready = (state_q == DATA) && (!dv_q || bus.core_ready_i) && (sent_q < total_q);

    always_comb begin
        state_d = state_q;
        kk_d    = kk_q;
        nn_d    = nn_q;
        ll_d    = ll_q;
        total_d = total_q;
        sent_d  = sent_q;
        hcnt_d  = hcnt_q;
        timer_d = timer_q;
        error_d = error_q;
        done_d  = 1'b0;
        hv_d    = 1'b0;
        hash_d  = hash_q;
        dv_d    = dv_q;
        data_d  = data_q;
        cmd_d   = cmd_q;
        ser_clr = 1'b0;
        ser_adv = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                kk_d    = cfg_kk_i;
                nn_d    = cfg_nn_i;
                ll_d    = cfg_ll_i;
                total_d = {1'b0, cfg_ll_i} + ((cfg_kk_i != 7'd0) ? CNT_W'(64) : CNT_W'(0));
                sent_d  = '0;
                hcnt_d  = '0;
                error_d = 1'b0;
                ser_clr = 1'b1;
                state_d = CONF;
            end
            CONF: if (bus.core_ready_i) begin
                ser_adv = 1'b1;
                if (ser_last) begin
                    ser_clr = 1'b1;
                    if (total_q == '0) begin
                        timer_d = TW'(TIMEOUT - 1);
                        state_d = WAIT_HASH;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (dv_q && bus.core_ready_i) begin
                    dv_d = 1'b0;
                    if (cmd_q == CMD_LAST) begin
                        timer_d = TW'(TIMEOUT - 1);
                        state_d = WAIT_HASH;
                    end
                end
                // msg_ready is already 0 once the LAST byte has been taken
                if (msg_ready && bus.msg_valid_i) begin
                    dv_d   = 1'b1;
                    data_d = bus.msg_data_i;
                    sent_d = sent_q + CNT_W'(1);
                    if (sent_q == total_q - CNT_W'(1)) cmd_d = CMD_LAST;
                    else if (sent_q == '0)             cmd_d = CMD_START;
                    else                               cmd_d = CMD_DATA;
                end
            end
            WAIT_HASH: begin
                if (bus.core_hash_v_i) begin
                    hv_d    = 1'b1;
                    hash_d  = bus.core_hash_i;
                    hcnt_d  = 7'd1;
                    state_d = HASH_OUT;
                end else if (timer_q == '0) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            HASH_OUT: begin
                if (hcnt_q == nn_eff) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (bus.core_hash_v_i) begin
                    hv_d   = 1'b1;
                    hash_d = bus.core_hash_i;
                    hcnt_d = hcnt_q + 7'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            kk_q    <= '0;
            nn_q    <= '0;
            ll_q    <= '0;
            total_q <= '0;
            sent_q  <= '0;
            hcnt_q  <= '0;
            timer_q <= '0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
            hv_q    <= 1'b0;
            hash_q  <= '0;
            dv_q    <= 1'b0;
            data_q  <= '0;
            cmd_q   <= CMD_CONF;
        end else begin
            state_q <= state_d;
            kk_q    <= kk_d;
            nn_q    <= nn_d;
            ll_q    <= ll_d;
            total_q <= total_d;
            sent_q  <= sent_d;
            hcnt_q  <= hcnt_d;
            timer_q <= timer_d;
            error_q <= error_d;
            done_q  <= done_d;
            hv_q    <= hv_d;
            hash_q  <= hash_d;
            dv_q    <= dv_d;
            data_q  <= data_d;
            cmd_q   <= cmd_d;
        end
    end

    assign bus.msg_ready_o  = msg_ready;
    assign bus.core_valid_o = (state_q == CONF) || dv_q;
    assign bus.core_data_o  = (state_q == CONF) ? ser_byte : data_q;
    assign bus.core_cmd_o   = (state_q == CONF) ? CMD_CONF : cmd_q;
    assign hash_valid_o     = hv_q;
    assign hash_o           = hash_q;
    assign busy_o           = (state_q != IDLE);
    assign done_o           = done_q;
    assign error_o          = error_q;

endmodule

// File: tb/tb_hash_seq.sv
// Directed bench for hash_seq: framing, handshake hold, stalls, timeout, reset abort.
module tb_hash_seq;
    import hash_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [6:0]  cfg_kk = '0, cfg_nn = '0;
    logic [63:0] cfg_ll = '0;
    logic        hash_valid_o, busy_o, done_o, error_o;
    logic [7:0]  hash_o;

    hash_seq_if ifc ();

    hash_seq #(.LL_W(64), .TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .cfg_kk_i     (cfg_kk),
        .cfg_nn_i     (cfg_nn),
        .cfg_ll_i     (cfg_ll),
        .bus          (ifc.master),
        .hash_valid_o (hash_valid_o),
        .hash_o       (hash_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [9:0] xfer_q[$];
    int         xcyc_q[$];
    logic [7:0] hq[$];
    int         hcyc_q[$];
    int         chash_cyc_q[$];
    logic [7:0] msgq[$];
    logic [7:0] hashq[$];
    int  done_n, done_cyc, err_cyc, acc_cnt, stall_after, stall_left, hold_viol;
    bit  err_prev = 1'b0, toggle = 1'b0, hold_pend = 1'b0, acc;
    logic [9:0] hold_val;
    int  mism, t_last, start_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        xfer_q.delete(); xcyc_q.delete(); hq.delete(); hcyc_q.delete(); chash_cyc_q.delete();
        done_n = 0; done_cyc = -1; err_cyc = -1; acc_cnt = 0;
        stall_after = -1; stall_left = 0; hold_viol = 0; hold_pend = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        if (ifc.core_valid_o && ifc.core_ready_i) begin
            xfer_q.push_back({ifc.core_cmd_o, ifc.core_data_o});
            xcyc_q.push_back(cyc);
        end
        if (hold_pend && (!ifc.core_valid_o || {ifc.core_cmd_o, ifc.core_data_o} != hold_val))
            hold_viol++;
        hold_pend = ifc.core_valid_o && !ifc.core_ready_i;
        hold_val  = {ifc.core_cmd_o, ifc.core_data_o};
        if (ifc.core_hash_v_i) chash_cyc_q.push_back(cyc);
        if (hash_valid_o) begin hq.push_back(hash_o); hcyc_q.push_back(cyc); end
        if (done_o) begin done_n++; done_cyc = cyc; end
        if (error_o && !err_prev) err_cyc = cyc;
        err_prev = error_o;
        acc = ifc.msg_valid_i && ifc.msg_ready_o;
        @(posedge clk);
        cyc++;
        #1;
        if (acc) begin void'(msgq.pop_front()); acc_cnt++; end
        if (stall_left > 0 && acc_cnt == stall_after) begin
            ifc.msg_valid_i = 1'b0;
            stall_left--;
        end else begin
            ifc.msg_valid_i = (msgq.size() > 0);
            ifc.msg_data_i  = (msgq.size() > 0) ? msgq[0] : 8'h00;
        end
        if (hashq.size() > 0) begin
            ifc.core_hash_v_i = 1'b1;
            ifc.core_hash_i   = hashq.pop_front();
        end else begin
            ifc.core_hash_v_i = 1'b0;
            ifc.core_hash_i   = 8'h00;
        end
        if (toggle) ifc.core_ready_i = ~ifc.core_ready_i;
    endtask

    task automatic start_job(input logic [6:0] kk, input logic [6:0] nn, input logic [63:0] ll);
        cfg_kk = kk; cfg_nn = nn; cfg_ll = ll;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_xfers(input int n, input int budget);
        for (int i = 0; i < budget && xfer_q.size() < n; i++) tick();
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_n == 0; i++) tick();
    endtask

    logic [7:0] t1_conf [10] = '{8'h00, 8'h20, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    initial begin
        ifc.msg_valid_i = 1'b0; ifc.msg_data_i = 8'h00; ifc.core_ready_i = 1'b1;
        ifc.core_hash_v_i = 1'b0; ifc.core_hash_i = 8'h00;
        clear_logs();

        // reset state
        repeat (3) tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_core_valid", ifc.core_valid_o, 0);
        chk("rst_msg_ready", ifc.msg_ready_o, 0);
        chk("rst_hash_valid", hash_valid_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_error", error_o, 0);
        rst = 1'b0;
        tick();

        // kk=0 nn=32 ll=3, message 61 62 63
        clear_logs();
        msgq = '{8'h61, 8'h62, 8'h63};
        start_job(7'd0, 7'd32, 64'd3);
        wait_xfers(13, 60);
        chk("t1_xfer_cnt", xfer_q.size(), 13);
        chk("t1_first_valid_lat", xcyc_q[0], start_cyc);
        mism = 0;
        for (int i = 0; i < 10; i++) if (xfer_q[i] !== {CMD_CONF, t1_conf[i]}) mism++;
        chk("t1_conf_bytes", mism, 0);
        chk("t1_start", xfer_q[10], {CMD_START, 8'h61});
        chk("t1_data", xfer_q[11], {CMD_DATA, 8'h62});
        chk("t1_last", xfer_q[12], {CMD_LAST, 8'h63});
        chk("t1_throughput", xcyc_q[12] - xcyc_q[10], 2);
        for (int i = 0; i < 32; i++) hashq.push_back(8'hA0 + 8'(i));
        wait_done(80);
        chk("t1_hash_cnt", hq.size(), 32);
        mism = 0;
        for (int i = 0; i < 32; i++) if (hq[i] !== 8'hA0 + 8'(i)) mism++;
        chk("t1_hash_bytes", mism, 0);
        chk("t1_hash_lat", hcyc_q[0] - chash_cyc_q[0], 1);
        chk("t1_done_cyc", done_cyc, hcyc_q[31] + 1);
        tick();
        chk("t1_done_pulses", done_n, 1);
        chk("t1_idle", busy_o, 0);

        // kk=32 ll=0: 64 key-block bytes; nn=0 means 64 digest bytes
        clear_logs();
        for (int i = 0; i < 64; i++) msgq.push_back(8'(i));
        start_job(7'd32, 7'd0, 64'd0);
        wait_xfers(74, 200);
        chk("t2_xfer_cnt", xfer_q.size(), 74);
        chk("t2_conf_kk", xfer_q[0], {CMD_CONF, 8'h20});
        chk("t2_conf_nn", xfer_q[1], {CMD_CONF, 8'h00});
        chk("t2_start", xfer_q[10], {CMD_START, 8'h00});
        chk("t2_last", xfer_q[73], {CMD_LAST, 8'h3F});
        mism = 0;
        for (int i = 11; i < 73; i++) if (xfer_q[i] !== {CMD_DATA, 8'(i - 10)}) mism++;
        chk("t2_key_body", mism, 0);
        tick(); tick();
        chk("t2_wait_valid", ifc.core_valid_o, 0);
        chk("t2_wait_busy", busy_o, 1);
        for (int i = 0; i < 66; i++) hashq.push_back(8'(i));
        wait_done(200);
        chk("t2_hash_cnt_nn0", hq.size(), 64);
        chk("t2_hash_last", hq[63], 8'h3F);
        chk("t2_done", done_n, 1);
        tick(); tick();

        // kk=0 ll=0: straight to WAIT_HASH, then timeout
        clear_logs();
        start_job(7'd0, 7'd4, 64'd0);
        wait_xfers(10, 40);
        t_last = xcyc_q[9];
        tick(); tick();
        chk("t3_xfer_cnt", xfer_q.size(), 10);
        chk("t3_wait_valid", ifc.core_valid_o, 0);
        chk("t3_wait_busy", busy_o, 1);
        for (int i = 0; i < 40 && err_cyc < 0; i++) tick();
        chk("t3_err_cyc", err_cyc, t_last + 17);
        chk("t3_err_idle", busy_o, 0);
        tick(); tick();
        chk("t3_err_sticky", error_o, 1);
        chk("t3_no_done", done_n, 0);

        // ll=1 with core_ready toggling; start clears the error
        clear_logs();
        msgq = '{8'h5A};
        toggle = 1'b1;
        start_job(7'd0, 7'd2, 64'd1);
        chk("t4_err_clear", error_o, 0);
        wait_xfers(11, 80);
        chk("t4_conf_nn", xfer_q[1], {CMD_CONF, 8'h02});
        chk("t4_conf_ll", xfer_q[2], {CMD_CONF, 8'h01});
        chk("t4_single_last", xfer_q[10], {CMD_LAST, 8'h5A});
        hashq = '{8'hC1, 8'hC2};
        wait_done(40);
        chk("t4_hash_cnt", hq.size(), 2);
        chk("t4_hash_1", hq[1], 8'hC2);
        chk("t4_done", done_n, 1);
        chk("t4_no_dup", xfer_q.size(), 11);
        chk("t4_hold", hold_viol, 0);
        toggle = 1'b0;
        ifc.core_ready_i = 1'b1;
        tick();

        // requester stalls 5 cycles after 3 bytes
        clear_logs();
        for (int i = 0; i < 8; i++) msgq.push_back(8'h10 + 8'(i));
        stall_after = 3; stall_left = 5;
        start_job(7'd0, 7'd1, 64'd8);
        wait_xfers(18, 80);
        chk("t5_xfer_cnt", xfer_q.size(), 18);
        chk("t5_pre_gap", xcyc_q[12] - xcyc_q[11], 1);
        chk("t5_stall_gap", xcyc_q[13] - xcyc_q[12], 6);
        mism = 0;
        for (int i = 11; i < 17; i++) if (xfer_q[i] !== {CMD_DATA, 8'h10 + 8'(i - 10)}) mism++;
        chk("t5_body", mism, 0);
        chk("t5_last", xfer_q[17], {CMD_LAST, 8'h17});
        hashq = '{8'h99};
        wait_done(40);
        chk("t5_hash", hq[0], 8'h99);
        chk("t5_done", done_n, 1);
        tick();

        // start while busy is ignored; reset mid-DATA aborts
        clear_logs();
        msgq = '{8'hE0, 8'hE1};
        start_job(7'd0, 7'd1, 64'd8);
        wait_xfers(12, 60);
        tick(); tick();
        start_job(7'd5, 7'd9, 64'd0);
        tick(); tick();
        chk("t6_busy_start_ign", xfer_q.size(), 12);
        chk("t6_busy", busy_o, 1);
        msgq.push_back(8'hE2);
        wait_xfers(13, 20);
        chk("t6_continue", xfer_q[12], {CMD_DATA, 8'hE2});
        msgq.push_back(8'hE3);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_valid", ifc.core_valid_o, 0);
        chk("t6_rst_data", ifc.core_data_o, 0);
        chk("t6_rst_cmd", ifc.core_cmd_o, 0);
        chk("t6_rst_ready", ifc.msg_ready_o, 0);
        chk("t6_rst_hash", {hash_valid_o, hash_o, done_o, error_o}, 0);
        rst = 1'b0;
        clear_logs();
        repeat (4) tick();
        chk("t6_no_flush", xfer_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hash_seq.md
# hash_seq

Host-side sequencer for the BLAKE2 byte-serial hashing core. It frames one hash job onto the core's 8-bit data port and its 2-bit command port:
- configuration bytes;
- optional key block and message bytes, forwarded from a requester stream;
- collection of the digest bytes.

It sits between an on-FPGA requester (test-vector ROM or loopback engine) and the core's `ui_in`/`uio_in`/`uio_out`/`uo_out` bus. It replaces the external Raspberry Pi PIO host for self-test builds.

## Interface
Parameters:
- `LL_W`, 64: message-length width in bits; must be a multiple of 8.
- `TIMEOUT`, 4096: cycles allowed in `WAIT_HASH` before an error is flagged.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `start_i`, in, 1: one-cycle job request; sampled only in `IDLE`.
- `cfg_kk_i`, in, 7: key length in bytes, 0..64.
- `cfg_nn_i`, in, 7: digest length in bytes, 1..64.
- `cfg_ll_i`, in, `LL_W`: message length in bytes.
- `msg_valid_i`, in, 1: requester byte valid.
- `msg_data_i`, in, 8: requester byte.
- `msg_ready_o`, out, 1: requester byte accepted when `msg_valid_i & msg_ready_o`.
- `core_data_o`, out, 8: byte to core (`ui_in`).
- `core_cmd_o`, out, 2: command to core (`data_cmd`).
- `core_valid_o`, out, 1: byte/command valid (`data_ctrl[0]`).
- `core_ready_i`, in, 1: core ready (`uio_out[3]`).
- `core_hash_v_i`, in, 1: digest byte valid (`uio_out[7]`).
- `core_hash_i`, in, 8: digest byte (`uo_out`).
- `hash_valid_o`, out, 1: digest byte out, one cycle per byte; no backpressure.
- `hash_o`, out, 8: digest byte out.
- `busy_o`, out, 1: high in every state except `IDLE`.
- `done_o`, out, 1: one-cycle pulse after the last digest byte.
- `error_o`, out, 1: sticky timeout flag; cleared by `rst` or an accepted `start_i`.

## Operation
Command encoding, fixed: `CMD_CONF`=0, `CMD_START`=1, `CMD_DATA`=2, `CMD_LAST`=3.

Core handshake:
- A core transfer occurs on any cycle where `core_valid_o & core_ready_i`.
- `core_data_o` and `core_cmd_o` are held stable while `core_valid_o & !core_ready_i`.

Job setup:
- In `IDLE`, `start_i` latches `kk`, `nn` and `ll` into registers.
- Total data bytes `T = ll + (kk != 0 ? 64 : 0)`, computed at `LL_W+1` bits.
- The requester supplies the key block, already zero-padded to 64 bytes, ahead of the message.

State machine:
- `IDLE` -> `CONF` on `start_i`.
- `CONF` sends `CFG_BYTES = 2 + LL_W/8` bytes, all with `CMD_CONF`, in this order: `kk`, `nn`, then `ll` little-endian. After the last config transfer: if `T == 0`, go to `WAIT_HASH`; otherwise go to `DATA`.
- `DATA` forwards requester bytes:
  - `msg_ready_o = (state == DATA) & (!core_valid_o | core_ready_i) & (sent_cnt < T)`.
  - Command is `CMD_START` on byte 0 and `CMD_LAST` on byte T-1. If T == 1, the single byte carries `CMD_LAST`. All other bytes carry `CMD_DATA`.
  - After the `CMD_LAST` transfer, go to `WAIT_HASH`.
- `WAIT_HASH`: `core_valid_o` is 0 and the timeout counter runs. The first `core_hash_v_i` goes to `HASH_OUT`, and that byte counts as digest byte 0. When the counter reaches `TIMEOUT`, set `error_o` and go to `IDLE` without pulsing `done_o`.
- `HASH_OUT`: each `core_hash_v_i` cycle is forwarded, registered, to `hash_valid_o`/`hash_o` and increments `hash_cnt`. When `hash_cnt` reaches `nn`, go to `IDLE` and pulse `done_o`. `core_hash_v_i` is ignored outside `WAIT_HASH` and `HASH_OUT`.

Boundary rules:
- `start_i` while `busy_o` is ignored.
- `core_hash_v_i` arriving in `DATA` is ignored; it is a core protocol violation.
- Config values are not range-checked; `nn == 0` is treated as 64.
- The requester may stall at any time; `core_valid_o` drops and the sequencer waits indefinitely, with no timeout in `DATA`.

## Timing
Reset values:
- All outputs are 0, including `error_o`.
- State is `IDLE`; all counters are 0.
- A reset mid-job aborts immediately, with no flush to the core.

Latencies:
- `start_i` to first `core_valid_o`: 1 cycle.
- Requester byte accepted in cycle N appears on `core_data_o` in cycle N+1.
- Sustained throughput is 1 byte per cycle while `core_ready_i` stays high.
- `core_hash_v_i` in cycle N gives `hash_valid_o` in cycle N+1.
- `done_o` coincides with the cycle after the last `hash_valid_o`.
- Timeout: `error_o` rises exactly `TIMEOUT` cycles after entering `WAIT_HASH`.

## Structure
- Package `hash_seq_pkg` holds:
  - `CMD_CONF`/`CMD_START`/`CMD_DATA`/`CMD_LAST` constants;
  - the state enum `{IDLE, CONF, DATA, WAIT_HASH, HASH_OUT}`;
  - the `CFG_BYTES` function of `LL_W`.
- The package is shared with the requester and the bench.
- One sub-module, `hash_seq_cfg_ser`: a byte serializer of `{ll, nn, kk}` with a byte index and last flag.

## Test plan
- kk=0, nn=32, ll=3, bytes 61 62 63, core ready always high:
  - core sees 10 CONF bytes: 00 20 03 00×7;
  - then START 61, DATA 62, LAST 63;
  - 32 core hash bytes appear delayed by 1 cycle, then `done_o` pulses.
- kk=32, ll=0: exactly 64 key-block bytes are sent (START … LAST) and then `WAIT_HASH` is entered. ll=0 with kk=0: `CONF` goes straight to `WAIT_HASH`.
- ll=1: the single byte is sent with `CMD_LAST`. `core_ready_i` is toggled 0/1 every cycle: the data byte is held stable while ready is low and no byte is lost or duplicated.
- Requester stalls 5 cycles mid-message: `core_valid_o` is 0 for those cycles and the sequence resumes correctly.
- `TIMEOUT`=16 with no `core_hash_v_i`: `error_o` rises 16 cycles after `WAIT_HASH` entry, state returns to `IDLE`, and the next `start_i` clears `error_o`.
- `rst` asserted during `DATA`: all outputs are 0 next cycle. `start_i` asserted while busy has no effect.
